frame_buffer_writer: RTL and testbench
======================================

// Module: frame_buffer_writer
// PURPOSE
//  Sits directly downstream of ray_marcher: captures its sparse (hcount, vcount, color, valid) pixel stream
//  into a double-buffered 4-bit frame store and serves the completed (front) frame to the display scan-out
//  path with fixed read latency. Buffer swap is requested by ray_marcher's new_frame pulse and performed
//  at the next display frame boundary, so the display never shows a partially rendered frame.
// PARAMETERS
//  DISPLAY_WIDTH   320  pixels per line
//  DISPLAY_HEIGHT  240  lines per frame
//  H_BITS          9    width of hcount ports
//  V_BITS          8    width of vcount ports
//  COLOR_BITS      4    bits per stored pixel
// PORTS
//  clk_in             in   1           system clock; all logic on rising edge
//  rst_in             in   1           asynchronous, active-high reset
//  hcount_in          in   H_BITS      write pixel column (from ray_marcher hcount_out)
//  vcount_in          in   V_BITS      write pixel row
//  color_in           in   COLOR_BITS  write pixel color
//  valid_in           in   1           write strobe; pixel written when high (subject to rules below)
//  new_frame_in       in   1           1-cycle pulse: render of back buffer complete
//  rd_hcount_in       in   H_BITS      display read column
//  rd_vcount_in       in   V_BITS      display read row
//  rd_frame_start_in  in   1           1-cycle pulse: display at frame boundary (vblank start)
//  rd_color_out       out  COLOR_BITS  front-buffer pixel, 2 cycles after rd address
//  front_sel_out      out  1           index of bank currently displayed
//  swap_pending_out   out  1           high while waiting for rd_frame_start_in to swap
//  swap_out           out  1           1-cycle pulse on the cycle the swap takes effect
//  dropped_count_out  out  16          saturating count of rejected write pixels
// BEHAVIOUR
//  Storage: two banks, DISPLAY_WIDTH*DISPLAY_HEIGHT entries each; addr = vcount*DISPLAY_WIDTH + hcount.
//  Reset (async): state=WRITING, front_sel_out=0, swap_pending_out=0, swap_out=0, rd_color_out=0,
//   dropped_count_out=0, read pipeline regs cleared. Memory contents not cleared. Reset mid-frame or
//   mid-swap abandons any pending swap; front bank returns to 0.
//  Write path: pixel registered once, written to back bank (~front_sel) the next cycle (1-cycle write latency).
//   Rejected (not written, dropped_count_out += 1, saturates at 16'hFFFF): hcount_in >= DISPLAY_WIDTH,
//   vcount_in >= DISPLAY_HEIGHT, or valid_in while state=SWAP_WAIT.
//  FSM:
//   WRITING:   new_frame_in & rd_frame_start_in -> swap this cycle, stay WRITING;
//              new_frame_in alone -> SWAP_WAIT (swap_pending_out=1).
//   SWAP_WAIT: rd_frame_start_in -> swap, -> WRITING. Further new_frame_in ignored.
//   Swap: front_sel_out toggles at the clock edge; swap_out high for the following cycle.
//  Simultaneous: valid_in on same cycle as new_frame_in belongs to the completed frame -> written into the
//   old back bank before the swap (write register captures bank select with the pixel).
//  Read path: stage1 registers address (out-of-range flagged) and front_sel; stage2 reads memory,
//   rd_color_out = 0 if flagged. Latency exactly 2 cycles; bank chosen by front_sel at address time,
//   so reads straddling a swap stay coherent per pixel.
//  Width: address width $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT); multiply done at full width, no truncation.
// TESTING  (bench uses DISPLAY_WIDTH=8, DISPLAY_HEIGHT=4, H_BITS=4, V_BITS=3)
//  1 Reset: assert rst_in mid-clock -> all outputs 0 immediately, front_sel_out=0, swap_pending_out=0.
//  2 Write (3,2,color 4'hA) valid, new_frame_in, then rd_frame_start_in 5 cycles later -> swap_pending_out
//    high 5 cycles, swap_out pulse, front_sel_out=1; read (3,2) -> rd_color_out=4'hA exactly 2 cycles later.
//  3 Out of range: write h=8 and v=4 -> dropped_count_out=2, no bank entry changed; read h=9 -> 0.
//  4 Valid pixel (0,0,4'h5) in SWAP_WAIT -> dropped, count+1; same-cycle valid+new_frame pixel (7,3,4'h3)
//    -> visible as 4'h3 in new front after swap.
//  5 new_frame_in and rd_frame_start_in same cycle -> immediate swap, swap_pending_out never high.
//  6 Drive 70000 rejected pixels -> dropped_count_out holds 16'hFFFF; reset during SWAP_WAIT -> pending cleared.

Source files
------------

// File: rtl/frame_buffer_writer.sv
// Double-buffered 4-bit frame store between ray_marcher and display scan-out.
// Back bank takes render writes; front bank is served with 2-cycle read latency.
module frame_buffer_writer #(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8,
  parameter int COLOR_BITS     = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [H_BITS-1:0]     hcount_in,
  input  logic [V_BITS-1:0]     vcount_in,
  input  logic [COLOR_BITS-1:0] color_in,
  input  logic                  valid_in,
  input  logic                  new_frame_in,
  input  logic [H_BITS-1:0]     rd_hcount_in,
  input  logic [V_BITS-1:0]     rd_vcount_in,
  input  logic                  rd_frame_start_in,
  output logic [COLOR_BITS-1:0] rd_color_out,
  output logic                  front_sel_out,
  output logic                  swap_pending_out,
  output logic                  swap_out,
  output logic [15:0]           dropped_count_out
);

  localparam int DEPTH = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] W_U = DISPLAY_WIDTH;
  localparam logic [31:0] H_U = DISPLAY_HEIGHT;

  typedef enum logic {
    S_WRITING,
    S_SWAP_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_swap;

  logic                  w_wr_oor;
  logic                  w_drop;
  logic                  w_wr_acc;
  logic [AW-1:0]         w_wr_addr;
  logic                  w_rd_oor;
  logic [AW-1:0]         w_rd_addr;

  logic                  r_wr_en;
  logic                  r_wr_bank;
  logic [AW-1:0]         r_wr_addr;
  logic [COLOR_BITS-1:0] r_wr_color;

  logic                  r_rd_oor;
  logic                  r_rd_bank;
  logic [AW-1:0]         r_rd_addr;

  logic [COLOR_BITS-1:0] r_mem0 [DEPTH];
  logic [COLOR_BITS-1:0] r_mem1 [DEPTH];

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      S_WRITING: begin
        if (new_frame_in) begin
          if (rd_frame_start_in) w_swap = 1'b1;
          else w_state_nxt = S_SWAP_WAIT;
        end
      end
      S_SWAP_WAIT: begin
        if (rd_frame_start_in) begin
          w_swap      = 1'b1;
          w_state_nxt = S_WRITING;
        end
      end
      default: w_state_nxt = S_WRITING;
    endcase
  end

  assign swap_pending_out = (r_state == S_SWAP_WAIT);

  assign w_wr_oor = (32'(hcount_in) >= W_U) || (32'(vcount_in) >= H_U);
  assign w_drop   = valid_in && (w_wr_oor || swap_pending_out);
  assign w_wr_acc = valid_in && !w_drop;
  // In-range coordinates always fit AW bits, so the product is exact.
  assign w_wr_addr = AW'(vcount_in) * AW'(DISPLAY_WIDTH) + AW'(hcount_in);

  assign w_rd_oor  = (32'(rd_hcount_in) >= W_U) || (32'(rd_vcount_in) >= H_U);
  assign w_rd_addr = AW'(rd_vcount_in) * AW'(DISPLAY_WIDTH) + AW'(rd_hcount_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state           <= S_WRITING;
      front_sel_out     <= 1'b0;
      swap_out          <= 1'b0;
      dropped_count_out <= '0;
      r_wr_en           <= 1'b0;
      r_wr_bank         <= 1'b0;
      r_wr_addr         <= '0;
      r_wr_color        <= '0;
      r_rd_oor          <= 1'b1;
      r_rd_bank         <= 1'b0;
      r_rd_addr         <= '0;
      rd_color_out      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      front_sel_out <= front_sel_out ^ w_swap;
      swap_out      <= w_swap;
      if (w_drop && dropped_count_out != 16'hFFFF)
        dropped_count_out <= dropped_count_out + 16'd1;
      // Bank is latched with the pixel so a same-cycle swap can't redirect it.
      r_wr_en    <= w_wr_acc;
      r_wr_bank  <= ~front_sel_out;
      r_wr_addr  <= w_wr_acc ? w_wr_addr : '0;
      r_wr_color <= color_in;
      r_rd_oor   <= w_rd_oor;
      r_rd_bank  <= front_sel_out;
      r_rd_addr  <= w_rd_oor ? '0 : w_rd_addr;
      if (r_rd_oor) rd_color_out <= '0;
      else if (r_rd_bank) rd_color_out <= r_mem1[r_rd_addr];
      else rd_color_out <= r_mem0[r_rd_addr];
    end
  end

  always_ff @(posedge clk_in) begin
    if (r_wr_en) begin
      if (r_wr_bank) r_mem1[r_wr_addr] <= r_wr_color;
      else r_mem0[r_wr_addr] <= r_wr_color;
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer on a tiny 8x4 display.
module tb_frame_buffer_writer;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [3:0] hcount_in;
  logic [2:0] vcount_in;
  logic [3:0] color_in;
  logic       valid_in;
  logic       new_frame_in;
  logic [3:0] rd_hcount_in;
  logic [2:0] rd_vcount_in;
  logic       rd_frame_start_in;
  logic [3:0] rd_color_out;
  logic       front_sel_out;
  logic       swap_pending_out;
  logic       swap_out;
  logic [15:0] dropped_count_out;

  int n_chk = 0;
  int n_pass = 0;

  frame_buffer_writer #(
    .DISPLAY_WIDTH(8),
    .DISPLAY_HEIGHT(4),
    .H_BITS(4),
    .V_BITS(3),
    .COLOR_BITS(4)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .color_in(color_in),
    .valid_in(valid_in),
    .new_frame_in(new_frame_in),
    .rd_hcount_in(rd_hcount_in),
    .rd_vcount_in(rd_vcount_in),
    .rd_frame_start_in(rd_frame_start_in),
    .rd_color_out(rd_color_out),
    .front_sel_out(front_sel_out),
    .swap_pending_out(swap_pending_out),
    .swap_out(swap_out),
    .dropped_count_out(dropped_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    valid_in          = 1'b0;
    new_frame_in      = 1'b0;
    rd_frame_start_in = 1'b0;
    hcount_in         = 4'd0;
    vcount_in         = 3'd0;
    color_in          = 4'd0;
  endtask

  task automatic do_read(input logic [3:0] h, input logic [2:0] v,
                         output logic [3:0] c1, output logic [3:0] c2);
    rd_hcount_in = h;
    rd_vcount_in = v;
    tick();
    c1 = rd_color_out;
    rd_hcount_in = 4'hF;
    rd_vcount_in = 3'd0;
    tick();
    c2 = rd_color_out;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle();
    rd_hcount_in = 4'hF;
    rd_vcount_in = 3'd0;
    repeat (2) tick();
    n_chk++;
    if (front_sel_out !== 1'b0 || swap_pending_out !== 1'b0 || swap_out !== 1'b0 ||
        dropped_count_out !== 16'd0 || rd_color_out !== 4'd0)
      $display("FAIL reset_hold: fs=%b sp=%b so=%b dc=%h rc=%h want all 0",
               front_sel_out, swap_pending_out, swap_out, dropped_count_out, rd_color_out);
    else n_pass++;
    rst_in = 1'b0;
    valid_in = 1'b1; hcount_in = 4'hF;
    new_frame_in = 1'b1; rd_frame_start_in = 1'b1;
    tick();
    idle();
    n_chk++;
    if (front_sel_out !== 1'b1 || swap_out !== 1'b1 || dropped_count_out !== 16'd1)
      $display("FAIL pre_reset_state: fs=%b so=%b dc=%h want 1 1 0001",
               front_sel_out, swap_out, dropped_count_out);
    else n_pass++;
    #3 rst_in = 1'b1;
    #1;
    n_chk++;
    if (front_sel_out !== 1'b0 || swap_pending_out !== 1'b0 || swap_out !== 1'b0 ||
        dropped_count_out !== 16'd0 || rd_color_out !== 4'd0)
      $display("FAIL async_reset: fs=%b sp=%b so=%b dc=%h rc=%h want all 0",
               front_sel_out, swap_pending_out, swap_out, dropped_count_out, rd_color_out);
    else n_pass++;
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_swap();
    int pend;
    logic [3:0] c1, c2;
    pend = 0;
    valid_in = 1'b1; hcount_in = 4'd3; vcount_in = 3'd2; color_in = 4'hA;
    new_frame_in = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      if (swap_pending_out === 1'b1) pend++;
      tick();
    end
    rd_frame_start_in = 1'b1;
    if (swap_pending_out === 1'b1) pend++;
    tick();
    rd_frame_start_in = 1'b0;
    n_chk++;
    if (pend !== 5) $display("FAIL pending_cycles: got %0d want 5", pend);
    else n_pass++;
    n_chk++;
    if (swap_out !== 1'b1 || front_sel_out !== 1'b1 || swap_pending_out !== 1'b0)
      $display("FAIL swap_edge: so=%b fs=%b sp=%b want 1 1 0",
               swap_out, front_sel_out, swap_pending_out);
    else n_pass++;
    tick();
    n_chk++;
    if (swap_out !== 1'b0) $display("FAIL swap_pulse_width: so=%b want 0", swap_out);
    else n_pass++;
    do_read(4'd3, 3'd2, c1, c2);
    n_chk++;
    if (c1 !== 4'h0) $display("FAIL read_latency_early: got %h want 0", c1);
    else n_pass++;
    n_chk++;
    if (c2 !== 4'hA) $display("FAIL read_3_2: got %h want a", c2);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [3:0] c1, c2;
    valid_in = 1'b1; hcount_in = 4'd0; vcount_in = 3'd1; color_in = 4'h6;
    tick();
    n_chk++;
    if (dropped_count_out !== 16'd0)
      $display("FAIL good_write_not_dropped: got %h want 0000", dropped_count_out);
    else n_pass++;
    hcount_in = 4'd8; vcount_in = 3'd0; color_in = 4'hF;
    tick();
    hcount_in = 4'd0; vcount_in = 3'd4; color_in = 4'hF;
    tick();
    idle();
    n_chk++;
    if (dropped_count_out !== 16'd2)
      $display("FAIL oor_dropped: got %h want 0002", dropped_count_out);
    else n_pass++;
    do_read(4'd9, 3'd0, c1, c2);
    n_chk++;
    if (c2 !== 4'h0) $display("FAIL read_oor: got %h want 0", c2);
    else n_pass++;
    new_frame_in = 1'b1; rd_frame_start_in = 1'b1;
    tick();
    idle();
    do_read(4'd0, 3'd1, c1, c2);
    n_chk++;
    if (c2 !== 4'h6 || front_sel_out !== 1'b0)
      $display("FAIL oor_no_alias: got %h fs=%b want 6 fs=0", c2, front_sel_out);
    else n_pass++;
  endtask

  task automatic test_swap_wait();
    logic [3:0] c1, c2;
    valid_in = 1'b1; hcount_in = 4'd7; vcount_in = 3'd3; color_in = 4'h3;
    new_frame_in = 1'b1;
    tick();
    n_chk++;
    if (swap_pending_out !== 1'b1 || dropped_count_out !== 16'd2)
      $display("FAIL last_pixel_accepted: sp=%b dc=%h want 1 0002",
               swap_pending_out, dropped_count_out);
    else n_pass++;
    hcount_in = 4'd0; vcount_in = 3'd0; color_in = 4'h5;
    tick();
    idle();
    n_chk++;
    if (dropped_count_out !== 16'd3)
      $display("FAIL swap_wait_drop: got %h want 0003", dropped_count_out);
    else n_pass++;
    rd_frame_start_in = 1'b1;
    tick();
    idle();
    n_chk++;
    if (front_sel_out !== 1'b1 || swap_out !== 1'b1)
      $display("FAIL swap_wait_swap: fs=%b so=%b want 1 1", front_sel_out, swap_out);
    else n_pass++;
    do_read(4'd7, 3'd3, c1, c2);
    n_chk++;
    if (c2 !== 4'h3) $display("FAIL read_7_3: got %h want 3", c2);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [3:0] c1, c2;
    int pend;
    pend = 0;
    valid_in = 1'b1; hcount_in = 4'd1; vcount_in = 3'd1; color_in = 4'h9;
    new_frame_in = 1'b1; rd_frame_start_in = 1'b1;
    if (swap_pending_out === 1'b1) pend++;
    tick();
    idle();
    if (swap_pending_out === 1'b1) pend++;
    n_chk++;
    if (front_sel_out !== 1'b0 || swap_out !== 1'b1)
      $display("FAIL immediate_swap: fs=%b so=%b want 0 1", front_sel_out, swap_out);
    else n_pass++;
    tick();
    if (swap_pending_out === 1'b1) pend++;
    n_chk++;
    if (pend !== 0) $display("FAIL no_pending: got %0d cycles want 0", pend);
    else n_pass++;
    do_read(4'd1, 3'd1, c1, c2);
    n_chk++;
    if (c2 !== 4'h9) $display("FAIL read_1_1: got %h want 9", c2);
    else n_pass++;
  endtask

  task automatic test_saturate_and_reset();
    valid_in = 1'b1; hcount_in = 4'hF; vcount_in = 3'd0;
    repeat (70000) @(posedge clk_in);
    #1;
    n_chk++;
    if (dropped_count_out !== 16'hFFFF)
      $display("FAIL saturate: got %h want ffff", dropped_count_out);
    else n_pass++;
    tick();
    idle();
    n_chk++;
    if (dropped_count_out !== 16'hFFFF)
      $display("FAIL saturate_hold: got %h want ffff", dropped_count_out);
    else n_pass++;
    new_frame_in = 1'b1;
    tick();
    idle();
    n_chk++;
    if (swap_pending_out !== 1'b1)
      $display("FAIL pending_before_reset: got %b want 1", swap_pending_out);
    else n_pass++;
    #3 rst_in = 1'b1;
    #1;
    n_chk++;
    if (swap_pending_out !== 1'b0 || dropped_count_out !== 16'd0 || front_sel_out !== 1'b0)
      $display("FAIL reset_in_swap_wait: sp=%b dc=%h fs=%b want 0 0000 0",
               swap_pending_out, dropped_count_out, front_sel_out);
    else n_pass++;
    rst_in = 1'b0;
    tick();
    rd_frame_start_in = 1'b1;
    tick();
    idle();
    n_chk++;
    if (swap_out !== 1'b0 || front_sel_out !== 1'b0 || swap_pending_out !== 1'b0)
      $display("FAIL swap_abandoned: so=%b fs=%b sp=%b want 0 0 0",
               swap_out, front_sel_out, swap_pending_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_swap();
    test_out_of_range();
    test_swap_wait();
    test_simultaneous();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
